// File: rtl/oprandb_buffpc_ctrl_if.sv
`default_nettype none
// ============================================================================
// oprandb_buffpc_ctrl_if : instruction-field / step-sequencing bundle. Rev 1.0
// ============================================================================
interface oprandb_buffpc_ctrl_if #(
  parameter int CNT_W = 3
);
  logic [4:0]       InsM;
  logic [1:0]       InsL;
  logic [CNT_W-1:0] Cnt;
  logic             Buff_PC;
  logic             OprandB;

  // master = instruction register side, slave = the sequencer
  modport master (output InsM, output InsL, input Cnt, input Buff_PC, input OprandB);
  modport slave  (input InsM, input InsL, output Cnt, output Buff_PC, output OprandB);
endinterface
`default_nettype wire

// File: rtl/oprandb_buffpc_ctrl.sv
`default_nettype none
// ============================================================================
// oprandb_buffpc_ctrl : micro-step counter with end-of-instruction and
// operand-B decode for the multicycle controller.                   Rev 1.0
// ============================================================================
module oprandb_buffpc_ctrl #(
  parameter int CNT_W = 3
) (
  input  logic                   clk,
  input  logic                   Rst,
  oprandb_buffpc_ctrl_if.slave   bus
);

  localparam logic [CNT_W-1:0] STEP_EXEC = CNT_W'(2);
  localparam logic [CNT_W-1:0] STEP_MEM  = CNT_W'(3);
  localparam logic [CNT_W-1:0] STEP_WB   = CNT_W'(4);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] last_step;
  logic             imm_op;
  logic             hlt_op;
  logic             past_decode;
  logic             buff_pc;

  // Unlisted opcodes (and X/Z in simulation) fall to the NOP defaults.
  always_comb begin
    last_step = STEP_EXEC;
    imm_op    = 1'b0;
    hlt_op    = 1'b0;
    case (bus.InsM)
      5'b00000: last_step = STEP_MEM;
      5'b00001: begin last_step = STEP_MEM;  imm_op = 1'b1; end
      5'b00010: begin last_step = STEP_MEM;  imm_op = 1'b1; end
      5'b00011: begin last_step = STEP_WB;   imm_op = 1'b1; end
      5'b00100: last_step = STEP_WB;
      5'b00101: begin last_step = STEP_MEM;  imm_op = 1'b1; end
      5'b00110: begin
        if (bus.InsL == 2'b00) last_step = STEP_MEM;
        else                   last_step = STEP_EXEC;
      end
      5'b00111: begin last_step = STEP_MEM;  imm_op = 1'b1; end
      5'b01000: begin last_step = STEP_MEM;  imm_op = 1'b1; end
      5'b01011: last_step = STEP_MEM;
      5'b10000: begin last_step = STEP_EXEC; imm_op = 1'b1; end
      5'b10001: begin last_step = STEP_MEM;  imm_op = 1'b1; end
      5'b10010: last_step = STEP_MEM;
      5'b10011: last_step = STEP_EXEC;
      5'b11000: begin last_step = STEP_EXEC; imm_op = 1'b1; end
      5'b11001: begin last_step = STEP_EXEC; imm_op = 1'b1; end
      5'b11100: begin
        if (bus.InsL == 2'b01) hlt_op = 1'b1;
      end
      default: ;
    endcase
  end

  // Fields are only meaningful once decode (step 1) has completed.
  assign past_decode = Rst && (cnt >= STEP_EXEC);
  assign buff_pc     = past_decode && !hlt_op && (cnt == last_step);

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      cnt <= '0;
    end else if (buff_pc) begin
      cnt <= '0;
    end else if (hlt_op && (cnt == STEP_EXEC)) begin
      cnt <= cnt;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign bus.Cnt     = cnt;
  assign bus.Buff_PC = buff_pc;
  assign bus.OprandB = past_decode && imm_op;

endmodule
`default_nettype wire

// File: tb/tb_oprandb_buffpc_ctrl.sv
`default_nettype none
// Scoreboard bench for oprandb_buffpc_ctrl: expected end step / operand-B
// pushed when an instruction is applied, checked as the DUT steps through it.
module tb_oprandb_buffpc_ctrl;

  typedef struct {
    string      name;
    logic [2:0] last;
    logic       imm;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fails;
  bit   mon_en;
  bit   exp_zero;
  exp_t q[$];

  oprandb_buffpc_ctrl_if #(.CNT_W(3)) bus ();

  oprandb_buffpc_ctrl #(.CNT_W(3)) dut (
    .clk (clk),
    .Rst (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Monitor: step-by-step comparison against the front of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (exp_zero) begin
        check("cnt_return", 32'(bus.Cnt), 0);
        exp_zero = 1'b0;
      end
      if (bus.Cnt < 3'd2) begin
        check("early_bpc", 32'(bus.Buff_PC), 0);
        check("early_opb", 32'(bus.OprandB), 0);
      end else if (q.size() == 0) begin
        check("bpc_no_instr", 32'(bus.Buff_PC), 0);
      end else begin
        check($sformatf("%s_opb", q[0].name), 32'(bus.OprandB), 32'(q[0].imm));
        check($sformatf("%s_bpc", q[0].name), 32'(bus.Buff_PC), 32'(bus.Cnt == q[0].last));
        if (bus.Buff_PC) begin
          check($sformatf("%s_last", q[0].name), 32'(bus.Cnt), 32'(q[0].last));
          void'(q.pop_front());
          exp_zero = 1'b1;
        end
      end
    end
  end

  task automatic wait_cnt1(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.Cnt != 3'd1 && n < 20);
    if (bus.Cnt != 3'd1) check($sformatf("%s_sync", name), 32'(bus.Cnt), 1);
    #1;
  endtask

  task automatic run_instr(input string name, input logic [4:0] op, input logic [1:0] fn,
                           input logic [2:0] last, input logic imm);
    exp_t e;
    int   n;
    wait_cnt1(name);
    bus.InsM = op;
    bus.InsL = fn;
    e.name = name;
    e.last = last;
    e.imm  = imm;
    q.push_back(e);
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (q.size() != 0) begin
      check($sformatf("%s_done", name), 32'(q.size()), 0);
      q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    n_checks = 0;
    n_fails  = 0;
    mon_en   = 1'b1;
    exp_zero = 1'b0;
    rst_n    = 1'b0;
    bus.InsM = 5'b11100;
    bus.InsL = 2'b00;

    repeat (2) begin
      @(negedge clk);
      check("rst_cnt", 32'(bus.Cnt), 0);
      check("rst_bpc", 32'(bus.Buff_PC), 0);
      check("rst_opb", 32'(bus.OprandB), 0);
    end
    #1 rst_n = 1'b1;

    run_instr("OUTR",  5'b11100, 2'b00, 3'd2, 1'b0);
    run_instr("ADD",   5'b00000, 2'b00, 3'd3, 1'b0);
    run_instr("ADDI",  5'b00111, 2'b00, 3'd3, 1'b1);
    run_instr("LDRri", 5'b00011, 2'b00, 3'd4, 1'b1);
    run_instr("LDRrr", 5'b00100, 2'b00, 3'd4, 1'b0);

    run_instr("ADC",   5'b00000, 2'b01, 3'd3, 1'b0);
    run_instr("SUB",   5'b00000, 2'b10, 3'd3, 1'b0);
    run_instr("SBB",   5'b00000, 2'b11, 3'd3, 1'b0);
    run_instr("LHI",   5'b00001, 2'b10, 3'd3, 1'b1);
    run_instr("LLI",   5'b00010, 2'b01, 3'd3, 1'b1);
    run_instr("STRri", 5'b00101, 2'b11, 3'd3, 1'b1);
    run_instr("STRrr", 5'b00110, 2'b00, 3'd3, 1'b0);
    run_instr("CMP",   5'b00110, 2'b01, 3'd2, 1'b0);
    run_instr("X0110", 5'b00110, 2'b11, 3'd2, 1'b0);
    run_instr("SUBI",  5'b01000, 2'b10, 3'd3, 1'b1);
    run_instr("MOV",   5'b01011, 2'b00, 3'd3, 1'b0);
    run_instr("JMP",   5'b10000, 2'b01, 3'd2, 1'b1);
    run_instr("JALrl", 5'b10001, 2'b00, 3'd3, 1'b1);
    run_instr("JALrr", 5'b10010, 2'b11, 3'd3, 1'b0);
    run_instr("JR",    5'b10011, 2'b00, 3'd2, 1'b0);
    run_instr("BCC",   5'b11000, 2'b00, 3'd2, 1'b1);
    run_instr("BCS",   5'b11000, 2'b01, 3'd2, 1'b1);
    run_instr("BEQ",   5'b11000, 2'b10, 3'd2, 1'b1);
    run_instr("BNE",   5'b11000, 2'b11, 3'd2, 1'b1);
    run_instr("BAL",   5'b11001, 2'b00, 3'd2, 1'b1);
    run_instr("X11100",5'b11100, 2'b11, 3'd2, 1'b0);
    run_instr("NOP1F", 5'b11111, 2'b00, 3'd2, 1'b0);
    run_instr("NOP09", 5'b01001, 2'b01, 3'd2, 1'b0);

    // HLT: freeze at step 2, then asynchronous reset between clock edges.
    wait_cnt1("HLT");
    mon_en   = 1'b0;
    exp_zero = 1'b0;
    bus.InsM = 5'b11100;
    bus.InsL = 2'b01;
    repeat (12) begin
      @(negedge clk);
      check("hlt_cnt", 32'(bus.Cnt), 2);
      check("hlt_bpc", 32'(bus.Buff_PC), 0);
      check("hlt_opb", 32'(bus.OprandB), 0);
    end
    #2 rst_n = 1'b0;
    #1 check("hlt_async_cnt", 32'(bus.Cnt), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Reset pulse in the middle of LDRri.
    wait_cnt1("LDRri_rst");
    bus.InsM = 5'b00011;
    bus.InsL = 2'b00;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.Cnt != 3'd3 && n < 20);
    check("ldr_mid_cnt", 32'(bus.Cnt), 3);
    check("ldr_mid_opb", 32'(bus.OprandB), 1);
    #2 rst_n = 1'b0;
    #1;
    check("ldr_rst_cnt", 32'(bus.Cnt), 0);
    check("ldr_rst_bpc", 32'(bus.Buff_PC), 0);
    check("ldr_rst_opb", 32'(bus.OprandB), 0);
    @(negedge clk);
    check("ldr_rst_hold", 32'(bus.Cnt), 0);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;

    run_instr("ADD_post", 5'b00000, 2'b00, 3'd3, 1'b0);
    run_instr("JMP_post", 5'b10000, 2'b00, 3'd2, 1'b1);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/oprandb_buffpc_ctrl.md
Name: oprandb_buffpc_ctrl

Overview:
- Cycle-sequencing slice of the multicycle RISC controller.
- Owns the 3-bit micro-step counter Cnt. Decodes the instruction fields InsM[15:11] and InsL[1:0] into two outputs:
  - Buff_PC: end-of-instruction strobe that returns Cnt to 0.
  - OprandB: ALU operand-B select, 1 = immediate, 0 = register.
- Sits between the instruction register and the datapath mux/PC buffer.

Parameters:
- CNT_W, 3, width of the step counter. Only 3 is supported.

Ports:
- clk  input  1  system clock, rising-edge.
- Rst  input  1  asynchronous, active-low reset.
- InsM  input  5  instruction bits [15:11]. Held stable by the IR from Cnt=1 until Buff_PC.
- InsL  input  2  instruction bits [1:0], function field.
- Cnt  output  3  current micro-step (0 = fetch, 1 = decode, 2+ = execute/mem/writeback).
- Buff_PC  output  1  last step of the current instruction. Combinational from Cnt/InsM/InsL.
- OprandB  output  1  operand-B select. Combinational.

Behaviour:
- Counter:
  - Rst low: Cnt=0 immediately.
  - On a rising clk edge with Rst high: Cnt = 0 if Buff_PC=1, else Cnt+1.
  - 3-bit wrap 7→0.
- Reset outputs: while Rst is low, Cnt=0, Buff_PC=0, OprandB=0.
- Cnt=0 and Cnt=1: Buff_PC=0 and OprandB=0 for every opcode. InsM is not yet valid at Cnt=0.
- Opcode decode (InsM; InsL only where stated), with Buff_PC final step:
  - 00000 ALU reg ADD/ADC/SUB/SBB (InsL 00/01/10/11): Cnt=3.
  - 00001 LHI: Cnt=3.
  - 00010 LLI: Cnt=3.
  - 00011 LDRri: Cnt=4.
  - 00100 LDRrr: Cnt=4.
  - 00101 STRri: Cnt=3.
  - 00110 with InsL=00 is STRrr: Cnt=3. With InsL=01 it is CMP: Cnt=2. Other InsL values: Cnt=2.
  - 00111 ADDI: Cnt=3.
  - 01000 SUBI: Cnt=3.
  - 01011 MOV: Cnt=3.
  - 10000 JMP: Cnt=2.
  - 10001 JALrl: Cnt=3.
  - 10010 JALrr: Cnt=3.
  - 10011 JR: Cnt=2.
  - 11000 Bcond BCC/BCS/BEQ/BNE: Cnt=2.
  - 11001 BAL: Cnt=2.
  - 11100 with InsL=00 is OutR: Cnt=2. With InsL=01 it is HLT. Other InsL values: Cnt=2.
  - Any other opcode, or InsM/InsL containing X/Z in simulation, is a NOP: Cnt=2.
- Buff_PC is 1 only when Cnt equals the final step of the decoded instruction.
- HLT:
  - Buff_PC is never asserted.
  - Counter advances to 2, then holds at 2 with no increment until Rst is asserted.
  - This freeze is the only case in which Cnt does not advance.
- OprandB:
  - Equals 1 when Cnt≥2, Rst high, and the opcode is immediate-type: LHI, LLI, LDRri, STRri, ADDI, SUBI, JMP, JALrl, Bcond, BAL.
  - Register-type opcodes (ALU reg, LDRrr, STRrr, CMP, MOV, JALrr, JR, OutR, HLT, NOP) give 0.
- Instruction length is Buff_PC step + 1 clocks. Next fetch starts with Cnt=0 on the edge after Buff_PC=1.
- Reset mid-instruction: outputs drop to 0 immediately. After Rst is released, counting resumes from 0 on the next edge.
- Changing InsM/InsL during Cnt≥1 is illegal. Outputs follow the new inputs combinationally; no latching is done.

Test Plan:
- Rst low for 2 clocks with InsM=11100, InsL=00:
  - Cnt=0, Buff_PC=0, OprandB=0 throughout.
  - After release, Cnt steps 0,1,2. Buff_PC=1 at Cnt=2, then Cnt returns to 0.
- ADD (00000/00) and then ADDI (00111): both give Buff_PC at Cnt=3.
  - OprandB=0 for ADD at all steps.
  - OprandB=1 for ADDI at Cnt=2,3 and 0 at Cnt=0,1.
- LDRri (00011) and then LDRrr (00100/00):
  - Both give Buff_PC at Cnt=4.
  - OprandB=1 at Cnt 2..4 for LDRri; 0 throughout for LDRrr.
- Sweep all 25 instructions back-to-back, applying InsM/InsL at Cnt=1:
  - Every Buff_PC step matches the table.
  - Cnt always returns to 0 on the following edge.
  - CMP (00110/01) ends at Cnt=2, while STRrr (00110/00) ends at 3.
- HLT (11100/01): Cnt reaches 2 and holds for ≥10 clocks with Buff_PC=0. Asserting Rst low forces Cnt=0 asynchronously, without waiting for a clock edge.
- Undefined opcode 11111: ends as a NOP at Cnt=2 with OprandB=0. Rst pulsed at Cnt=3 during LDRri clears all outputs mid-edge-interval.
